// File: rtl/pixel_stream_source.sv
// rtl/pixel_stream_source.sv - frame reader feeding a valid/ready RGB pixel stream
module pixel_stream_source #(
    parameter int IMG_W      = 64,
    parameter int IMG_H      = 64,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_valid,
    input  logic [23:0]       mem_rd_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [7:0]        R,
    output logic [7:0]        G,
    output logic [7:0]        B,
    output logic              sof,
    output logic              eol,
    output logic              eof
);

    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int CW1 = CW + 1;
    localparam int XW  = $clog2(IMG_W);
    localparam int YW  = $clog2(IMG_H + 1);

    localparam logic [CW:0]       DEPTH_C   = CW1'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [XW-1:0]     X_LAST    = XW'(IMG_W - 1);
    localparam logic [YW-1:0]     Y_LAST    = YW'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_count;
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [23:0]       r_fifo [FIFO_DEPTH];
    logic [XW-1:0]     r_x;
    logic [YW-1:0]     r_y;
    logic              r_err;

    logic              w_active;
    logic [CW:0]       w_credit_sum;
    logic              w_issue;
    logic              w_push;
    logic              w_spurious;
    logic              w_pix_valid;
    logic              w_pop;
    logic              w_x_last;
    logic              w_eof;
    logic              w_start;
    logic [23:0]       w_head;

    // A read is only issued while the words already in flight plus the words
    // already buffered leave room, so every response has a FIFO slot waiting.
    assign w_active     = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign w_credit_sum = {1'b0, r_outstanding} + {1'b0, r_count};
    assign w_issue      = (r_state == S_FETCH) && (w_credit_sum < DEPTH_C);
    assign w_push       = mem_rd_valid && w_active && (r_outstanding != '0);
    assign w_spurious   = mem_rd_valid && w_active && (r_outstanding == '0);
    assign w_pix_valid  = (r_count != '0);
    assign w_pop        = w_pix_valid && pix_ready;
    assign w_x_last     = (r_x == X_LAST);
    assign w_eof        = w_pix_valid && w_x_last && (r_y == Y_LAST);
    assign w_start      = (r_state == S_IDLE) && start;
    assign w_head       = r_fifo[r_rd_ptr];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state: fetch until the last address is requested, drain until eof leaves
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_FETCH;
            S_FETCH: if (w_issue && (r_addr == LAST_ADDR)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_pop && w_eof) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read address, in-flight read count and sticky error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr        <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            if (w_start) begin
                r_addr <= '0;
                r_err  <= 1'b0;
            end else if (w_issue) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            if (w_spurious) r_err <= 1'b1;
            case ({w_issue, w_push})
                2'b10:   r_outstanding <= r_outstanding + CW'(1);
                2'b01:   r_outstanding <= r_outstanding - CW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are only observed behind a non-zero count
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= mem_rd_data;
    end

    // Output position counters advance on each transferred pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_start) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_pop) begin
            if (w_eof) begin
                r_x <= '0;
                r_y <= '0;
            end else if (w_x_last) begin
                r_x <= '0;
                r_y <= r_y + YW'(1);
            end else begin
                r_x <= r_x + XW'(1);
            end
        end
    end

    assign busy      = w_active;
    assign done      = (r_state == S_DONE);
    assign err       = r_err;
    assign mem_rd_en = w_issue;
    assign mem_addr  = w_issue ? r_addr : '0;
    assign pix_valid = w_pix_valid;
    assign R         = w_pix_valid ? w_head[23:16] : 8'd0;
    assign G         = w_pix_valid ? w_head[15:8]  : 8'd0;
    assign B         = w_pix_valid ? w_head[7:0]   : 8'd0;
    assign sof       = w_pix_valid && (r_x == '0) && (r_y == '0);
    assign eol       = w_pix_valid && w_x_last;
    assign eof       = w_eof;

endmodule

// File: tb/tb_pixel_stream_source.sv
// tb/tb_pixel_stream_source.sv - directed self-checking bench for pixel_stream_source
module tb_pixel_stream_source;

    localparam int W  = 4;
    localparam int H  = 2;
    localparam int N  = W * H;
    localparam int D  = 4;
    localparam int AW = 12;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          err;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_valid;
    logic [23:0]   mem_rd_data;
    logic          pix_valid;
    logic          pix_ready;
    logic [7:0]    R;
    logic [7:0]    G;
    logic [7:0]    B;
    logic          sof;
    logic          eol;
    logic          eof;

    logic          m_valid;
    logic [23:0]   m_data;
    logic          inj_valid;
    logic [23:0]   inj_data;

    int n_checks;
    int n_err;
    int lat_min;
    int lat_max;
    int cyc;
    int mcyc;
    int last_due;
    int issued;
    int xfers;
    int idx;
    int frames;
    int done_cnt;
    int eof_cyc;
    logic        prev_stall;
    logic [30:0] prev_vec;

    typedef struct {
        logic [23:0] d;
        int          due;
    } rsp_t;
    rsp_t rq[$];

    assign mem_rd_valid = m_valid | inj_valid;
    assign mem_rd_data  = inj_valid ? inj_data : m_data;

    pixel_stream_source #(
        .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .FIFO_DEPTH(D)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .err(err),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_valid(mem_rd_valid),
        .mem_rd_data(mem_rd_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .R(R), .G(G), .B(B), .sof(sof), .eol(eol), .eof(eof)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pix_of(input int a);
        if (a == 0) return 24'hAABBCC;
        return {8'(a * 7 + 3), 8'(a + 64), 8'(255 - a)};
    endfunction

    // Frame memory: in-order responses with latency lat_min..lat_max
    always @(posedge clk) begin
        int due;
        #1;
        mcyc++;
        m_valid = 1'b0;
        if (rq.size() > 0 && rq[0].due <= mcyc) begin
            m_valid = 1'b1;
            m_data  = rq[0].d;
            void'(rq.pop_front());
        end
        if (mem_rd_en) begin
            due = mcyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            rq.push_back('{d: pix_of(int'(mem_addr)), due: due});
        end
    end

    // Monitor: addresses, credits, pixel contents/markers, stall stability, done timing
    always @(negedge clk) begin
        logic [26:0] got_p;
        logic [26:0] exp_p;
        logic [30:0] cur_vec;
        #1;
        cyc++;
        if (rst_n) begin
            if (!busy && !done) begin
                issued = 0;
                xfers  = 0;
                idx    = 0;
            end
            if (mem_rd_en) begin
                check("addr", 32'(mem_addr), 32'(issued));
                check("credit", (issued - xfers < D) ? 32'd1 : 32'd0, 32'd1);
                issued++;
            end
            cur_vec = {pix_valid, R, G, B, sof, eol, eof};
            if (prev_stall) check("stable", 32'(cur_vec), 32'(prev_vec));
            if (pix_valid && pix_ready) begin
                got_p = {R, G, B, sof, eol, eof};
                exp_p = {pix_of(idx), idx == 0, (idx % W) == W - 1, idx == N - 1};
                check("pix", 32'(got_p), 32'(exp_p));
                xfers++;
                if (eof) begin
                    check("issued_at_eof", 32'(issued), 32'(N));
                    idx     = 0;
                    frames++;
                    eof_cyc = cyc;
                end else begin
                    idx++;
                end
            end
            prev_stall = pix_valid && !pix_ready;
            prev_vec   = cur_vec;
            if (done) begin
                done_cnt++;
                check("done_lat", 32'(cyc), 32'(eof_cyc + 1));
            end
        end
    end

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int d0;
        bit ok;
        d0 = done_cnt;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #2;
            if (done_cnt != d0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        int f0;
        int d0;
        bit found;
        n_checks = 0; n_err = 0; cyc = 0; mcyc = 0; last_due = 0;
        issued = 0; xfers = 0; idx = 0; frames = 0; done_cnt = 0; eof_cyc = -10;
        prev_stall = 1'b0; prev_vec = '0;
        m_valid = 1'b0; m_data = '0; inj_valid = 1'b0; inj_data = '0;
        lat_min = 1; lat_max = 1;
        rst_n = 1'b0; start = 1'b0; pix_ready = 1'b1;
        #1;
        check("reset_outs", 32'({busy, done, err, mem_rd_en, mem_addr, pix_valid, R, G, B, sof, eol, eof}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // T1: latency 1, always ready
        f0 = frames;
        start_pulse();
        wait_done();
        check("t1_frames", 32'(frames - f0), 32'd1);

        // T2: fixed latency 3, then random latencies 1..3
        lat_min = 3; lat_max = 3;
        f0 = frames;
        start_pulse();
        wait_done();
        lat_min = 1; lat_max = 3;
        start_pulse();
        wait_done();
        check("t2_frames", 32'(frames - f0), 32'd2);

        // T3: downstream stall mid-frame
        lat_min = 1; lat_max = 1;
        f0 = frames;
        start_pulse();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #2;
            if (xfers >= 3) begin
                found = 1'b1;
                break;
            end
        end
        check("t3_reach", 32'(found), 32'd1);
        @(negedge clk);
        pix_ready = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        check("t3_rd_en_off", 32'(mem_rd_en), 32'd0);
        check("t3_valid_held", 32'(pix_valid), 32'd1);
        @(negedge clk);
        pix_ready = 1'b1;
        wait_done();
        check("t3_frames", 32'(frames - f0), 32'd1);

        // T4: start pulses during FETCH and DRAIN are ignored
        f0 = frames;
        d0 = done_cnt;
        start_pulse();
        start_pulse();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #2;
            if (busy && !mem_rd_en && issued == N) begin
                found = 1'b1;
                break;
            end
        end
        check("t4_drain", 32'(found), 32'd1);
        start_pulse();
        wait_done();
        repeat (20) @(negedge clk);
        #2;
        check("t4_dones", 32'(done_cnt - d0), 32'd1);
        check("t4_frames", 32'(frames - f0), 32'd1);
        check("t4_idle", 32'(busy), 32'd0);

        // T5: reset while requesting address 5, stale response in IDLE, restart
        lat_min = 2; lat_max = 2;
        start_pulse();
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #2;
            if (mem_rd_en && mem_addr == AW'(5)) begin
                found = 1'b1;
                break;
            end
        end
        check("t5_addr5", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_outs", 32'({busy, done, err, mem_rd_en, mem_addr, pix_valid, R, G, B, sof, eol, eof}), 32'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(negedge clk);
        inj_valid = 1'b1;
        inj_data  = 24'h123456;
        @(negedge clk);
        inj_valid = 1'b0;
        repeat (6) @(negedge clk);
        #2;
        check("t5_err_idle", 32'(err), 32'd0);
        check("t5_no_pix", 32'(pix_valid), 32'd0);
        f0 = frames;
        start_pulse();
        wait_done();
        check("t5_frames", 32'(frames - f0), 32'd1);

        // T6: spurious response with nothing outstanding sets err; next start clears it
        lat_min = 3; lat_max = 3;
        f0 = frames;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        inj_valid = 1'b1;
        inj_data  = 24'hDEAD00;
        @(negedge clk);
        inj_valid = 1'b0;
        #2;
        check("t6_err_set", 32'(err), 32'd1);
        wait_done();
        check("t6_frames", 32'(frames - f0), 32'd1);
        @(negedge clk);
        #2;
        check("t6_err_sticky", 32'(err), 32'd1);
        start_pulse();
        #2;
        check("t6_err_clr", 32'(err), 32'd0);
        wait_done();
        check("t6_frames2", 32'(frames - f0), 32'd2);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
